// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch initiator for the single-cycle CPU.
// Holds the PC, drives the instruction memory's active-low read strobe and
// byte address, captures the returned big-endian word and presents it to
// decode through a valid/ready handshake. Redirects restart fetch at a new
// PC. An illegal fetch address (misaligned or past the end of memory) parks
// the block in a sticky fault state that only reset clears.
//
// Ports:
//   clk         in   rising-edge clock
//   nrst        in   asynchronous active-low reset
//   nrd         out  memory read strobe, active-low
//   addr        out  byte address of the word being read
//   dataIn      in   memory word, byte at addr in [31:24]
//   inst        out  captured instruction
//   instPC      out  address inst was fetched from
//   instValid   out  inst/instPC valid for decode
//   instReady   in   decode accepts inst this cycle
//   redirect    in   load redirectPC and restart fetch
//   redirectPC  in   redirect target
//   fault       out  sticky fetch-address error
module inst_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_BYTES   = 100,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        nrst,
  output logic        nrd,
  output logic [31:0] addr,
  input  logic [31:0] dataIn,
  output logic [31:0] inst,
  output logic [31:0] instPC,
  output logic        instValid,
  input  logic        instReady,
  input  logic        redirect,
  input  logic [31:0] redirectPC,
  output logic        fault
);

  localparam logic [1:0] START = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  localparam logic [2:0]  WAITC    = 3'(WAIT_CYCLES);
  localparam logic [32:0] LAST_BYTE = 33'(MEM_BYTES - 1);

  logic [1:0]  state;
  logic [31:0] pc;
  logic [2:0]  cnt;

  // Word-aligned and the whole word fits in memory. Done in 33 bits so a PC
  // near 2^32 cannot wrap around and look legal.
  function automatic logic legal(input logic [31:0] a);
    logic [32:0] last;
    last = {1'b0, a} + 33'd3;
    return (a[1:0] == 2'b00) && (last <= LAST_BYTE);
  endfunction

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= START;
      pc        <= RESET_PC;
      cnt       <= 3'd0;
      nrd       <= 1'b1;
      addr      <= 32'd0;
      inst      <= 32'd0;
      instPC    <= 32'd0;
      instValid <= 1'b0;
      fault     <= 1'b0;
    end else if (redirect && state != FAULT) begin
      // Redirect beats everything: drop any in-flight read or held
      // instruction (a same-edge handshake is simply absorbed).
      instValid <= 1'b0;
      cnt       <= 3'd0;
      if (legal(redirectPC)) begin
        pc    <= redirectPC;
        addr  <= redirectPC;
        nrd   <= 1'b0;
        state <= FETCH;
      end else begin
        fault <= 1'b1;
        nrd   <= 1'b1;
        state <= FAULT;
      end
    end else begin
      case (state)
        START: begin
          if (legal(RESET_PC)) begin
            pc    <= RESET_PC;
            addr  <= RESET_PC;
            nrd   <= 1'b0;
            cnt   <= 3'd0;
            state <= FETCH;
          end else begin
            fault <= 1'b1;
            nrd   <= 1'b1;
            state <= FAULT;
          end
        end
        FETCH: begin
          if (cnt != WAITC) begin
            cnt <= cnt + 3'd1;
          end else begin
            inst      <= dataIn;
            instPC    <= pc;
            instValid <= 1'b1;
            nrd       <= 1'b1;
            pc        <= pc + 32'd4;
            state     <= HOLD;
          end
        end
        HOLD: begin
          // pc already points at the next word; its legality decides
          // whether the next read is issued or the block faults.
          if (instReady) begin
            instValid <= 1'b0;
            cnt       <= 3'd0;
            if (legal(pc)) begin
              addr  <= pc;
              nrd   <= 1'b0;
              state <= FETCH;
            end else begin
              fault <= 1'b1;
              nrd   <= 1'b1;
              state <= FAULT;
            end
          end
        end
        default: begin
          // FAULT: sticky until reset; inst/instPC keep their last values.
          fault     <= 1'b1;
          nrd       <= 1'b1;
          instValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch. dut0 uses default parameters, dut1 uses
// WAIT_CYCLES=2. A byte-array memory model answers reads while nrd is low.
module tb_inst_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [0:99];

  function automatic logic [31:0] rdw(input logic [31:0] a);
    int i;
    if (a > 32'd96) return 32'h0;
    i = int'(a);
    return {mem[i], mem[i+1], mem[i+2], mem[i+3]};
  endfunction

  // dut0 (WAIT_CYCLES=0)
  logic        nrst0, nrd0, instValid0, instReady0, redirect0, fault0;
  logic [31:0] addr0, dataIn0, inst0, instPC0, redirectPC0;
  assign dataIn0 = nrd0 ? 32'hDEADBEEF : rdw(addr0);

  inst_fetch dut0 (
    .clk(clk), .nrst(nrst0), .nrd(nrd0), .addr(addr0), .dataIn(dataIn0),
    .inst(inst0), .instPC(instPC0), .instValid(instValid0),
    .instReady(instReady0), .redirect(redirect0), .redirectPC(redirectPC0),
    .fault(fault0)
  );

  // dut1 (WAIT_CYCLES=2)
  logic        nrst1, nrd1, instValid1, instReady1, redirect1, fault1;
  logic [31:0] addr1, dataIn1, inst1, instPC1, redirectPC1;
  assign dataIn1 = nrd1 ? 32'hDEADBEEF : rdw(addr1);

  inst_fetch #(.WAIT_CYCLES(2)) dut1 (
    .clk(clk), .nrst(nrst1), .nrd(nrd1), .addr(addr1), .dataIn(dataIn1),
    .inst(inst1), .instPC(instPC1), .instValid(instValid1),
    .instReady(instReady1), .redirect(redirect1), .redirectPC(redirectPC1),
    .fault(fault1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++; if (nrd0 !== 1'b1) begin failures++; $display("FAIL rst_nrd got=%h exp=1", nrd0); end
    checks++; if (addr0 !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", addr0); end
    checks++; if (inst0 !== 32'h0) begin failures++; $display("FAIL rst_inst got=%h exp=0", inst0); end
    checks++; if (instPC0 !== 32'h0) begin failures++; $display("FAIL rst_instpc got=%h exp=0", instPC0); end
    checks++; if (instValid0 !== 1'b0) begin failures++; $display("FAIL rst_valid got=%h exp=0", instValid0); end
    checks++; if (fault0 !== 1'b0) begin failures++; $display("FAIL rst_fault got=%h exp=0", fault0); end
    nrst0 = 1'b1;
  endtask

  task automatic test_basic();
    tick(); // E1
    checks++; if (nrd0 !== 1'b0) begin failures++; $display("FAIL e1_nrd got=%h exp=0", nrd0); end
    checks++; if (addr0 !== 32'h0) begin failures++; $display("FAIL e1_addr got=%h exp=0", addr0); end
    tick(); // E2
    checks++; if (inst0 !== 32'h20080005) begin failures++; $display("FAIL e2_inst got=%h exp=20080005", inst0); end
    checks++; if (instPC0 !== 32'h0) begin failures++; $display("FAIL e2_instpc got=%h exp=0", instPC0); end
    checks++; if (instValid0 !== 1'b1) begin failures++; $display("FAIL e2_valid got=%h exp=1", instValid0); end
    checks++; if (nrd0 !== 1'b1) begin failures++; $display("FAIL e2_nrd got=%h exp=1", nrd0); end
    tick(); // E3
    checks++; if (nrd0 !== 1'b0 || addr0 !== 32'h4) begin failures++; $display("FAIL e3_read got nrd=%h addr=%h exp nrd=0 addr=4", nrd0, addr0); end
    tick(); // E4
    checks++; if (inst0 !== 32'h8C090004) begin failures++; $display("FAIL e4_inst got=%h exp=8c090004", inst0); end
    checks++; if (instPC0 !== 32'h4) begin failures++; $display("FAIL e4_instpc got=%h exp=4", instPC0); end
  endtask

  task automatic test_backpressure();
    instReady0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (inst0 !== 32'h8C090004 || instPC0 !== 32'h4 || addr0 !== 32'h4 || nrd0 !== 1'b1 || instValid0 !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold%0d got inst=%h pc=%h addr=%h nrd=%h v=%h exp 8c090004/4/4/1/1", k, inst0, instPC0, addr0, nrd0, instValid0);
      end
    end
    instReady0 = 1'b1;
    tick();
    checks++; if (nrd0 !== 1'b0 || addr0 !== 32'h8 || instValid0 !== 1'b0) begin failures++; $display("FAIL bp_fetch8 got nrd=%h addr=%h v=%h exp 0/8/0", nrd0, addr0, instValid0); end
    tick();
    checks++; if (inst0 !== 32'hADACAFAE || instPC0 !== 32'h8) begin failures++; $display("FAIL bp_inst8 got inst=%h pc=%h exp adacafae/8", inst0, instPC0); end
  endtask

  task automatic test_seq_fault();
    redirect0 = 1'b1; redirectPC0 = 32'd92;
    tick(); // redirect wins over the same-edge handshake
    redirect0 = 1'b0;
    checks++; if (nrd0 !== 1'b0 || addr0 !== 32'd92 || instValid0 !== 1'b0) begin failures++; $display("FAIL sq_redir got nrd=%h addr=%h v=%h exp 0/5c/0", nrd0, addr0, instValid0); end
    tick();
    checks++; if (inst0 !== 32'hF9F8FBFA || instPC0 !== 32'd92) begin failures++; $display("FAIL sq_inst92 got inst=%h pc=%h exp f9f8fbfa/5c", inst0, instPC0); end
    tick();
    checks++; if (nrd0 !== 1'b0 || addr0 !== 32'd96) begin failures++; $display("FAIL sq_read96 got nrd=%h addr=%h exp 0/60", nrd0, addr0); end
    tick();
    checks++; if (inst0 !== 32'hC5C4C7C6 || instPC0 !== 32'd96 || instValid0 !== 1'b1 || fault0 !== 1'b0) begin failures++; $display("FAIL sq_inst96 got inst=%h pc=%h v=%h f=%h exp c5c4c7c6/60/1/0", inst0, instPC0, instValid0, fault0); end
    tick(); // accept edge, next pc=100 is illegal
    checks++; if (fault0 !== 1'b1 || nrd0 !== 1'b1 || instValid0 !== 1'b0) begin failures++; $display("FAIL sq_fault got f=%h nrd=%h v=%h exp 1/1/0", fault0, nrd0, instValid0); end
    checks++; if (inst0 !== 32'hC5C4C7C6 || instPC0 !== 32'd96 || addr0 !== 32'd96) begin failures++; $display("FAIL sq_fault_keep got inst=%h pc=%h addr=%h exp c5c4c7c6/60/60", inst0, instPC0, addr0); end
    redirect0 = 1'b1; redirectPC0 = 32'h0;
    tick();
    redirect0 = 1'b0;
    tick();
    checks++; if (fault0 !== 1'b1 || nrd0 !== 1'b1 || addr0 !== 32'd96) begin failures++; $display("FAIL sq_redir_ign got f=%h nrd=%h addr=%h exp 1/1/60", fault0, nrd0, addr0); end
    nrst0 = 1'b0;
    #1;
    checks++; if (fault0 !== 1'b0 || nrd0 !== 1'b1) begin failures++; $display("FAIL sq_rst_clear got f=%h nrd=%h exp 0/1", fault0, nrd0); end
    tick();
    nrst0 = 1'b1;
    tick();
    checks++; if (nrd0 !== 1'b0 || addr0 !== 32'h0) begin failures++; $display("FAIL sq_restart got nrd=%h addr=%h exp 0/0", nrd0, addr0); end
    tick();
    checks++; if (inst0 !== 32'h20080005 || instValid0 !== 1'b1) begin failures++; $display("FAIL sq_restart_inst got inst=%h v=%h exp 20080005/1", inst0, instValid0); end
  endtask

  task automatic test_bad_redirect();
    redirect0 = 1'b1; redirectPC0 = 32'h42;
    tick();
    redirect0 = 1'b0;
    checks++; if (fault0 !== 1'b1 || nrd0 !== 1'b1 || instValid0 !== 1'b0) begin failures++; $display("FAIL br_42 got f=%h nrd=%h v=%h exp 1/1/0", fault0, nrd0, instValid0); end
    nrst0 = 1'b0;
    tick();
    nrst0 = 1'b1;
    redirect0 = 1'b1; redirectPC0 = 32'h61;
    tick(); // redirect in START takes priority over the reset fetch
    redirect0 = 1'b0;
    checks++; if (fault0 !== 1'b1 || nrd0 !== 1'b1 || addr0 !== 32'h0) begin failures++; $display("FAIL br_61 got f=%h nrd=%h addr=%h exp 1/1/0", fault0, nrd0, addr0); end
    nrst0 = 1'b0;
    tick();
    nrst0 = 1'b1;
  endtask

  task automatic test_async_reset();
    tick();
    tick();
    redirect0 = 1'b1; redirectPC0 = 32'h20;
    tick();
    redirect0 = 1'b0;
    checks++; if (nrd0 !== 1'b0 || addr0 !== 32'h20) begin failures++; $display("FAIL ar_fetch got nrd=%h addr=%h exp 0/20", nrd0, addr0); end
    #2 nrst0 = 1'b0;
    #1;
    checks++; if (nrd0 !== 1'b1 || addr0 !== 32'h0 || instValid0 !== 1'b0) begin failures++; $display("FAIL ar_async got nrd=%h addr=%h v=%h exp 1/0/0", nrd0, addr0, instValid0); end
    tick();
    nrst0 = 1'b1;
    tick();
    checks++; if (nrd0 !== 1'b0 || addr0 !== 32'h0) begin failures++; $display("FAIL ar_e1 got nrd=%h addr=%h exp 0/0", nrd0, addr0); end
    tick();
    checks++; if (inst0 !== 32'h20080005 || instPC0 !== 32'h0) begin failures++; $display("FAIL ar_e2 got inst=%h pc=%h exp 20080005/0", inst0, instPC0); end
  endtask

  task automatic test_wait_redirect();
    nrst1 = 1'b1;
    tick(); // E1
    checks++; if (nrd1 !== 1'b0 || addr1 !== 32'h0) begin failures++; $display("FAIL wr_e1 got nrd=%h addr=%h exp 0/0", nrd1, addr1); end
    tick(); // E2, cnt becomes 1
    checks++; if (nrd1 !== 1'b0 || instValid1 !== 1'b0) begin failures++; $display("FAIL wr_e2 got nrd=%h v=%h exp 0/0", nrd1, instValid1); end
    redirect1 = 1'b1; redirectPC1 = 32'h40;
    tick(); // E3 redirect
    redirect1 = 1'b0;
    checks++; if (nrd1 !== 1'b0 || addr1 !== 32'h40 || instValid1 !== 1'b0 || inst1 !== 32'h0) begin failures++; $display("FAIL wr_redir got nrd=%h addr=%h v=%h inst=%h exp 0/40/0/0", nrd1, addr1, instValid1, inst1); end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (instValid1 !== 1'b0 || nrd1 !== 1'b0) begin failures++; $display("FAIL wr_wait%0d got v=%h nrd=%h exp 0/0", k, instValid1, nrd1); end
    end
    tick();
    checks++; if (instValid1 !== 1'b1 || inst1 !== 32'hE5E4E7E6 || instPC1 !== 32'h40 || nrd1 !== 1'b1) begin failures++; $display("FAIL wr_cap got v=%h inst=%h pc=%h nrd=%h exp 1/e5e4e7e6/40/1", instValid1, inst1, instPC1, nrd1); end
  endtask

  initial begin
    for (int i = 8; i < 100; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[0] = 8'h20; mem[1] = 8'h08; mem[2] = 8'h00; mem[3] = 8'h05;
    mem[4] = 8'h8C; mem[5] = 8'h09; mem[6] = 8'h00; mem[7] = 8'h04;
    nrst0 = 1'b0; instReady0 = 1'b1; redirect0 = 1'b0; redirectPC0 = 32'h0;
    nrst1 = 1'b0; instReady1 = 1'b1; redirect1 = 1'b0; redirectPC1 = 32'h0;
    test_reset();
    test_basic();
    test_backpressure();
    test_seq_fault();
    test_bad_redirect();
    test_async_reset();
    test_wait_redirect();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
